// File: rtl/pwm_bus_pkg.sv
// pwm_bus_pkg: shared widths, FSM state codes and master ids for the pwm_register bus.
package pwm_bus_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

endpackage

// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter: shares the pwm_register port between an APB-lite host (M0) and an I2C bridge (M1),
// fixed priority to M0 with a starvation guard that forces M1 through.
module pwm_reg_arbiter
    import pwm_bus_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_psc_i,
    input  logic              rst_n_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              reg_wr_en_o,
    output logic              reg_rd_en_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              busy_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(RD_LATENCY + 1);

    logic [1:0]        state_q, state_d;
    master_e           gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pick_m1;
    logic              capture;

    always_comb begin
        pick_m1    = m1_req_i && (!m0_req_i || starve_q == SW'(STARVE_LIMIT));
        capture    = state_q == S_RD_WAIT && cnt_q == CW'(RD_LATENCY - 1);
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        cnt_d      = state_q == S_RD_WAIT ? cnt_q + 1'b1 : '0;
        m0_rdata_d = capture && gnt_q == M0 ? reg_rdata_i : m0_rdata_q;
        m1_rdata_d = capture && gnt_q == M1 ? reg_rdata_i : m1_rdata_q;
        case (state_q)
            S_IDLE: begin
                // M1 waiting but not picked implies an M0 grant below the limit, so no saturation test needed
                starve_d = (!m1_req_i || pick_m1) ? '0 : starve_q + 1'b1;
                if (m0_req_i || m1_req_i) begin
                    state_d = S_ISSUE;
                    gnt_d   = pick_m1 ? M1 : M0;
                    we_d    = pick_m1 ? m1_we_i : m0_we_i;
                    addr_d  = pick_m1 ? m1_addr_i : m0_addr_i;
                    wdata_d = pick_m1 ? m1_wdata_i : m0_wdata_i;
                end
            end
            S_ISSUE:   state_d = we_q ? S_DONE : S_RD_WAIT;
            S_RD_WAIT: state_d = capture ? S_DONE : S_RD_WAIT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            gnt_q      <= M0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            starve_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            starve_q   <= starve_d;
            cnt_q      <= cnt_d;
        end
    end

    assign reg_wr_en_o = state_q == S_ISSUE && we_q;
    assign reg_rd_en_o = state_q == S_ISSUE && !we_q;
    assign m0_ack_o    = state_q == S_DONE && gnt_q == M0;
    assign m1_ack_o    = state_q == S_DONE && gnt_q == M1;
    assign busy_o      = state_q != S_IDLE;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// tb_pwm_reg_arbiter: directed and random traffic from two masters, checked against a
// transaction-timeline model that predicts strobe/ack/busy cycles from grant decisions.
module tb_pwm_reg_arbiter;

    localparam int RD_LAT = 1;
    localparam int STARVE = 4;

    logic        clk_psc_i = 1'b0;
    logic        rst_n_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [7:0]  m0_addr_i, m1_addr_i;
    logic [15:0] m0_wdata_i, m1_wdata_i, reg_rdata_i;
    logic        m0_ack_o, m1_ack_o, reg_wr_en_o, reg_rd_en_o, busy_o;
    logic [15:0] m0_rdata_o, m1_rdata_o, reg_wdata_o;
    logic [7:0]  reg_addr_o;

    pwm_reg_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LATENCY(RD_LAT), .STARVE_LIMIT(STARVE)) dut (
        .clk_psc_i(clk_psc_i), .rst_n_i(rst_n_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o),
        .reg_wr_en_o(reg_wr_en_o), .reg_rd_en_o(reg_rd_en_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_psc_i = ~clk_psc_i;

    int checks = 0;
    int failures = 0;

    // Timeline model: ring of per-cycle expectations scheduled at each grant
    int          cyc_n, free_at, starve, cap_t;
    bit          cap_m, ack0_seen, ack1_seen, rand_rd;
    logic [15:0] mr0, mr1;
    bit          e_wr[64], e_rd[64], e_ack0[64], e_ack1[64];
    logic [7:0]  e_addr[64];
    logic [15:0] e_wdata[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_at = cyc_n;
        starve  = 0;
        cap_t   = -1;
        mr0     = '0;
        mr1     = '0;
        for (int k = 0; k < 64; k++) begin
            e_wr[k] = 0; e_rd[k] = 0; e_ack0[k] = 0; e_ack1[k] = 0;
        end
    endtask

    task automatic model_step();
        int i, s, a;
        bit g, we;
        i = cyc_n % 64;
        chk("wr_en", 32'(reg_wr_en_o), 32'(e_wr[i]));
        chk("rd_en", 32'(reg_rd_en_o), 32'(e_rd[i]));
        chk("m0_ack", 32'(m0_ack_o), 32'(e_ack0[i]));
        chk("m1_ack", 32'(m1_ack_o), 32'(e_ack1[i]));
        chk("busy", 32'(busy_o), 32'(cyc_n < free_at));
        chk("m0_rdata", 32'(m0_rdata_o), 32'(mr0));
        chk("m1_rdata", 32'(m1_rdata_o), 32'(mr1));
        if (e_wr[i] || e_rd[i]) chk("reg_addr", 32'(reg_addr_o), 32'(e_addr[i]));
        if (e_wr[i]) chk("reg_wdata", 32'(reg_wdata_o), 32'(e_wdata[i]));
        e_wr[i] = 0; e_rd[i] = 0; e_ack0[i] = 0; e_ack1[i] = 0;
        if (cyc_n == cap_t) begin
            if (cap_m) mr1 = reg_rdata_i;
            else mr0 = reg_rdata_i;
        end
        if (cyc_n >= free_at) begin
            g = m1_req_i && (!m0_req_i || starve == STARVE);
            starve = (!m1_req_i || g) ? 0 : (starve < STARVE ? starve + 1 : starve);
            if (m0_req_i || m1_req_i) begin
                we = g ? m1_we_i : m0_we_i;
                s = (cyc_n + 1) % 64;
                e_wr[s] = we;
                e_rd[s] = !we;
                e_addr[s] = g ? m1_addr_i : m0_addr_i;
                e_wdata[s] = g ? m1_wdata_i : m0_wdata_i;
                a = cyc_n + 2 + (we ? 0 : RD_LAT);
                if (g) e_ack1[a % 64] = 1;
                else e_ack0[a % 64] = 1;
                if (!we) begin
                    cap_t = cyc_n + 1 + RD_LAT;
                    cap_m = g;
                end
                free_at = a + 1;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk_psc_i);
        model_step();
        ack0_seen = m0_ack_o;
        ack1_seen = m1_ack_o;
        cyc_n++;
        @(posedge clk_psc_i);
        #1;
        if (rand_rd) reg_rdata_i = 16'($urandom);
    endtask

    task automatic wait_ack(input int m, input int max, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(m == 0 ? ack0_seen : ack1_seen) && n < max);
    endtask

    task automatic drive_rand();
        if (!m0_req_i || ack0_seen) begin
            m0_req_i = $urandom_range(0, 2) != 0;
            m0_we_i = 1'($urandom);
            m0_addr_i = 8'($urandom);
            m0_wdata_i = 16'($urandom);
        end
        if (!m1_req_i || ack1_seen) begin
            m1_req_i = $urandom_range(0, 1) != 0;
            m1_we_i = 1'($urandom);
            m1_addr_i = 8'($urandom);
            m1_wdata_i = 16'($urandom);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        rst_n_i = 1'b0;
        {m0_req_i, m0_we_i, m1_req_i, m1_we_i} = '0;
        {m0_addr_i, m1_addr_i} = '0;
        {m0_wdata_i, m1_wdata_i, reg_rdata_i} = '0;
        rand_rd = 0; ack0_seen = 0; ack1_seen = 0; cyc_n = 0;
        model_reset();
        repeat (2) @(posedge clk_psc_i);
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_wr_en", 32'(reg_wr_en_o), 0);
        chk("rst_rd_en", 32'(reg_rd_en_o), 0);
        chk("rst_acks", 32'({m0_ack_o, m1_ack_o}), 0);
        chk("rst_addr", 32'(reg_addr_o), 0);
        chk("rst_rdata", 32'({m0_rdata_o, m1_rdata_o}), 0);
        rst_n_i = 1'b1;

        // M0 lone write
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 8'h04; m0_wdata_i = 16'h1234;
        wait_ack(0, 20, n);
        m0_req_i = 0;
        chk("wr_latency", 32'(n), 3);

        // M1 lone read
        reg_rdata_i = 16'hBEEF;
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 8'h08;
        wait_ack(1, 20, n);
        m1_req_i = 0;
        chk("rd_latency", 32'(n), 3 + RD_LAT);
        chk("rd_data", 32'(m1_rdata_o), 32'h0000BEEF);

        // simultaneous requests
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 8'h20; m0_wdata_i = 16'hAAAA;
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 8'h30; m1_wdata_i = 16'h5555;
        wait_ack(0, 20, n);
        m0_req_i = 0;
        chk("both_m0_first", 32'(n), 3);
        wait_ack(1, 20, n);
        m1_req_i = 0;
        chk("both_m1_next", 32'(n), 3);

        // starvation guard
        cyc();
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 8'h0C;
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 8'h01; m0_wdata_i = 16'h0001;
        cnt = 0;
        for (int k = 0; k < 60 && !ack1_seen; k++) begin
            cyc();
            if (ack0_seen) begin
                cnt++;
                m0_addr_i = 8'($urandom);
                m0_wdata_i = 16'($urandom);
            end
        end
        chk("starve_m0_grants", 32'(cnt), STARVE);
        chk("starve_m1_served", 32'(ack1_seen), 1);
        wait_ack(0, 20, n);
        m0_req_i = 0; m1_req_i = 0;
        chk("starve_cleared", 32'(n), 3);

        // inputs change after grant
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 8'h10; m0_wdata_i = 16'h0BAD;
        cyc();
        m0_req_i = 0; m0_addr_i = 8'h55; m0_wdata_i = 16'h0000;
        cyc();
        chk("hold_addr", 32'(reg_addr_o), 32'h10);
        cnt = 0;
        repeat (4) begin
            cyc();
            cnt += int'(ack0_seen);
        end
        chk("drop_ack_once", 32'(cnt), 1);

        // reset while waiting for read data
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 8'h40;
        cyc();
        cyc();
        chk("busy_rd_wait", 32'(busy_o), 1);
        m0_req_i = 0;
        rst_n_i = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_strobes", 32'({reg_wr_en_o, reg_rd_en_o}), 0);
        chk("arst_acks", 32'({m0_ack_o, m1_ack_o}), 0);
        model_reset();
        repeat (2) @(posedge clk_psc_i);
        #1;
        rst_n_i = 1'b1;
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 8'h44; m0_wdata_i = 16'hCAFE;
        wait_ack(0, 20, n);
        m0_req_i = 0;
        chk("post_rst_write", 32'(n), 3);

        // random traffic
        rand_rd = 1;
        for (int k = 0; k < 600; k++) begin
            drive_rand();
            cyc();
        end
        m0_req_i = 0; m1_req_i = 0;
        repeat (8) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
